// File: rtl/gate_truth_table_checker.sv
// Exhaustive stimulus driver and truth-table checker for a small combinational gate.
// Optional first-mismatch capture ports are enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_truth_table_checker #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8,
  parameter int GATE_SEL      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  output logic [N_INPUTS-1:0] vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic                first_fail_valid,
  output logic [N_INPUTS-1:0] first_fail_vec
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SLAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  settle;
  logic           expv;
  logic           mism;
  logic [ERR_W-1:0] err_nxt;

  // Unknown selector values fall back to OR.
  always_comb begin
    case (GATE_SEL)
      1:       expv = &vec;
      2:       expv = ^vec;
      3:       expv = ~|vec;
      default: expv = |vec;
    endcase
    mism    = (op != expv);
    err_nxt = err_count;
    if (mism && (err_count != '1))
      err_nxt = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      settle    <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            settle    <= '0;
            vec       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
`endif
          end
        end
        DRIVE: begin
          if (settle == SLAST) begin
            settle <= '0;
            state  <= SAMPLE;
          end else begin
            settle <= settle + CW'(1);
          end
        end
        SAMPLE: begin
          err_count <= err_nxt;
`ifdef GATE_CHK_FIRST_FAIL_EN
          if (mism && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec;
          end
`endif
          if (vec == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            vec   <= vec + N_INPUTS'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
